rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Parametrised N-requester round-robin arbiter with registered one-hot grants and a per-grant hold quantum. It generalises the team's two-requester request-queue arbiter, which is fixed at two ports and alternates grants only on simultaneous requests. It sits between N bus masters or request queues and a single shared resource. Grants are fair (rotating priority) and glitch-free, and a configurable quantum lets a holder keep the resource for bursts.

## Interface
- N, default 4: number of requesters; legal range N ≥ 2.
- QUANTUM, default 1: maximum consecutive cycles one requester holds the grant while others wait; legal range QUANTUM ≥ 1.
- IDW, derived as $clog2(N): width of grant_id; not overridden by the user.
- clock  input  1  rising-edge clock, the only clock in the block.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i is requester i, level-sensitive.
- lock  input  1  holder-lock request; the port exists only with RR_ARB_LOCK_EN.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  registered; equals |grant.
- grant_id  output  IDW  registered binary index of the granted requester; 0 when grant_valid=0.

## Operation
- State registers:
  - grant (N bits)
  - ptr (IDW bits): index of the highest-priority requester
  - hold_cnt ($clog2(QUANTUM+1) bits)
- Reset (asynchronous, takes effect immediately on reset=1):
  - grant=0, grant_valid=0, grant_id=0
  - ptr=0, hold_cnt=0
- Let g be the current holder, when grant_valid=1. Each rising edge, one of three cases applies, evaluated in order:
  1. **HOLD**: grant_valid=1, req[g]=1, and either hold_cnt < QUANTUM-1 or no other req bit is set. Result: grant is unchanged and hold_cnt increments, saturating at QUANTUM-1.
  2. **ROTATE**: any req bit is set and HOLD does not apply. Result:
     - The winner is the first set req bit found scanning ptr, ptr+1, … modulo N.
     - grant becomes one-hot at the winner, hold_cnt=0, ptr=(winner+1) mod N.
     - Because ptr already points past g, g is considered last.
  3. **IDLE**: req is all zero. Result: grant=0, hold_cnt=0, ptr unchanged.
- Pointer wrap: when the winner is N-1, ptr wraps to 0.
- With QUANTUM=1, all requests active, the block performs strict per-cycle round-robin. For N=2 with both requests held, the grant sequence is 0,1,0,1…
- A requester that drops req while holding the grant loses it at the next edge. The freed slot goes to the next requester in rotation, or to IDLE if none is requesting.
- grant is always one-hot or zero; two grant bits are never set at once.
- grant_id and grant_valid are registered together with grant and are always consistent with it.
- Power-up case: ptr=0 after reset, so requester 0 has top priority for the first arbitration.

## Timing
- Latency is one cycle. req sampled at edge k produces grant visible after edge k, i.e. during cycle k+1.
- A holder's grant persists in the cycle during which it deasserts req. Re-arbitration happens at the next edge.
- There is no combinational path from req or lock to any output.
- Reset asserted mid-grant clears all outputs asynchronously, without waiting for a clock edge.
- After reset deasserts, the first grant appears one edge after a sampled request.
- Simultaneous new requests are resolved by ptr, never by fixed index, except for the first arbitration after reset.

## Configuration
- RR_ARB_LOCK_EN defined:
  - The lock port exists.
  - If lock=1, grant_valid=1 and req[g]=1, HOLD applies regardless of hold_cnt or competing requests. hold_cnt saturates at QUANTUM-1.
  - When lock deasserts, normal quantum rules resume. With a saturated hold_cnt and others waiting, ROTATE occurs at the next edge.
  - lock is ignored when grant_valid=0 or req[g]=0.
- RR_ARB_LOCK_EN undefined:
  - The lock port and its logic are absent.
  - Behaviour is exactly the three-case rule above.

## Test plan
- **Reset:** assert reset mid-operation with req=4'b1111 → grant=0, grant_valid=0, grant_id=0 immediately. First grant after release is grant=4'b0001.
- **Single request:** N=4, QUANTUM=1, req=4'b0100 held 5 cycles → grant=4'b0100, grant_id=2 from the cycle after the first sample onward. Drop req → grant=0 one edge later.
- **Strict round-robin:** N=4, QUANTUM=1, req=4'b1111 held → grant_id sequence 0,1,2,3,0,1…, each lasting 1 cycle.
- **Quantum bursts:** N=4, QUANTUM=3, req=4'b1111 held → each of ids 0,1,2,3 holds for 3 consecutive cycles, then rotates, with wrap to 0.
- **Pointer fairness:** grant 2 alone, drop req[2], then assert req=4'b1001 → grant_id=3 first, then 0.
- **Lock (RR_ARB_LOCK_EN):** QUANTUM=2, req=4'b0011, lock=1 while id 0 is granted → id 0 holds for 6 cycles. Deassert lock → grant_id=1 at the next edge.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter -- N-requester round-robin arbiter with registered one-hot
// grants and a per-grant hold quantum.
//
// Optional feature macro: RR_ARB_LOCK_EN (adds the i_lock port, which lets
// the current holder keep the grant past its quantum).
//
// Parameters:
//   N        number of requesters (>= 2)
//   QUANTUM  max consecutive cycles one holder keeps the grant while others
//            wait (>= 1)
//   IDW      derived, $clog2(N); width of o_grant_id
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        asynchronous active-high reset
//   i_req[N]       level-sensitive request vector, bit i = requester i
//   i_lock         holder-lock request (only with RR_ARB_LOCK_EN)
//   o_grant[N]     registered one-hot grant, or all zero
//   o_grant_valid  registered, equals |o_grant
//   o_grant_id     registered binary index of the holder, 0 when idle
module rr_arbiter #(
  parameter  int N       = 4,
  parameter  int QUANTUM = 1,
  localparam int IDW     = $clog2(N)
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [N-1:0]   i_req,
`ifdef RR_ARB_LOCK_EN
  input  logic           i_lock,
`endif
  output logic [N-1:0]   o_grant,
  output logic           o_grant_valid,
  output logic [IDW-1:0] o_grant_id
);

  localparam int HW = $clog2(QUANTUM + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(QUANTUM - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

  // State
  logic [N-1:0]   r_grant;
  logic           r_grant_valid;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_ptr;
  logic [HW-1:0]  r_hold_cnt;

  // Next-state
  logic [N-1:0]   w_grant_next;
  logic           w_grant_valid_next;
  logic [IDW-1:0] w_grant_id_next;
  logic [IDW-1:0] w_ptr_next;
  logic [HW-1:0]  w_hold_cnt_next;

  logic           w_holder_req;
  logic           w_others_req;
  logic           w_quantum_left;
  logic           w_lock_hold;
  logic           w_hold;
  logic [IDW-1:0] w_winner;

  // Holder still requesting, and whether anyone else is waiting.
  assign w_holder_req   = |(i_req & r_grant);
  assign w_others_req   = |(i_req & ~r_grant);
  assign w_quantum_left = (r_hold_cnt < HOLD_MAX);

`ifdef RR_ARB_LOCK_EN
  assign w_lock_hold = i_lock;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_hold = r_grant_valid & w_holder_req &
                  (w_quantum_left | ~w_others_req | w_lock_hold);

  // Rotating-priority search: scan offsets from the far end back towards
  // ptr so the last hit (smallest offset from ptr) wins.
  always_comb begin
    w_winner = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (i_req[(int'(r_ptr) + off) % N]) begin
        w_winner = IDW'((int'(r_ptr) + off) % N);
      end
    end
  end

  always_comb begin
    w_grant_next       = r_grant;
    w_grant_valid_next = r_grant_valid;
    w_grant_id_next    = r_grant_id;
    w_ptr_next         = r_ptr;
    w_hold_cnt_next    = r_hold_cnt;
    if (w_hold) begin
      if (r_hold_cnt < HOLD_MAX) begin
        w_hold_cnt_next = r_hold_cnt + 1'b1;
      end
    end else if (|i_req) begin
      w_grant_next           = '0;
      w_grant_next[w_winner] = 1'b1;
      w_grant_valid_next     = 1'b1;
      w_grant_id_next        = w_winner;
      w_hold_cnt_next        = '0;
      // Pointer moves just past the winner, so the winner ranks last next time.
      w_ptr_next = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;
    end else begin
      w_grant_next       = '0;
      w_grant_valid_next = 1'b0;
      w_grant_id_next    = '0;
      w_hold_cnt_next    = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
    end else begin
      r_grant       <= w_grant_next;
      r_grant_valid <= w_grant_valid_next;
      r_grant_id    <= w_grant_id_next;
      r_ptr         <= w_ptr_next;
      r_hold_cnt    <= w_hold_cnt_next;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter -- directed self-checking bench for rr_arbiter.
// Three instances (QUANTUM = 1, 2, 3, N = 4) see the same request stream;
// expected grant ids are hand-computed per cycle.
module tb_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         lock;

  logic [N-1:0] g1, g2, g3;
  logic         v1, v2, v3;
  logic [1:0]   id1, id2, id3;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter #(.N(N), .QUANTUM(1)) dut_q1 (
    .i_clock(clk), .i_reset(rst), .i_req(req),
`ifdef RR_ARB_LOCK_EN
    .i_lock(lock),
`endif
    .o_grant(g1), .o_grant_valid(v1), .o_grant_id(id1)
  );

  rr_arbiter #(.N(N), .QUANTUM(2)) dut_q2 (
    .i_clock(clk), .i_reset(rst), .i_req(req),
`ifdef RR_ARB_LOCK_EN
    .i_lock(lock),
`endif
    .o_grant(g2), .o_grant_valid(v2), .o_grant_id(id2)
  );

  rr_arbiter #(.N(N), .QUANTUM(3)) dut_q3 (
    .i_clock(clk), .i_reset(rst), .i_req(req),
`ifdef RR_ARB_LOCK_EN
    .i_lock(lock),
`endif
    .o_grant(g3), .o_grant_valid(v3), .o_grant_id(id3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full check of one instance against an expected id (valid implied).
  task automatic check_q1(input string tag, input int eid);
    check_eq({tag, " q1 id"},    32'(id1), 32'(eid));
    check_eq({tag, " q1 grant"}, 32'(g1),  32'(1 << eid));
    check_eq({tag, " q1 valid"}, 32'(v1),  32'd1);
    $display("%s: q1 grant=%b id=%0d", tag, g1, id1);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    lock = 1'b0;
    #2;
    check_eq("reset grant", 32'(g1), 32'd0);
    check_eq("reset valid", 32'(v1), 32'd0);
    check_eq("reset id",    32'(id1), 32'd0);
    tick();
    rst = 1'b0;

    // Single request held 5 cycles, then dropped.
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_q1("single", 2);
    end
    req = '0;
    tick();
    check_eq("drop grant", 32'(g1), 32'd0);
    check_eq("drop valid", 32'(v1), 32'd0);
    check_eq("drop id",    32'(id1), 32'd0);
    $display("drop: q1 grant=%b", g1);

    // ptr now points at 3, so requester 3 wins before 0.
    req = 4'b1001;
    tick();
    check_q1("fair first", 3);
    tick();
    check_q1("fair second", 0);

    // Reset mid-grant with everything requesting clears outputs at once.
    req = 4'b1111;
    tick();
    rst = 1'b1;
    #2;
    check_eq("async rst grant q1", 32'(g1), 32'd0);
    check_eq("async rst valid q1", 32'(v1), 32'd0);
    check_eq("async rst id q1",    32'(id1), 32'd0);
    check_eq("async rst grant q3", 32'(g3), 32'd0);
    $display("async reset: q1 grant=%b q3 grant=%b", g1, g3);
    tick();
    rst = 1'b0;

    // All requesting: q1 strict round-robin, q2/q3 bursts, all from id 0.
    for (int k = 0; k < 13; k++) begin
      tick();
      check_q1("rr", k % 4);
      check_eq("burst q2 id",    32'(id2), 32'((k / 2) % 4));
      check_eq("burst q3 id",    32'(id3), 32'((k / 3) % 4));
      check_eq("burst q3 grant", 32'(g3),  32'(1 << ((k / 3) % 4)));
      check_eq("burst q3 valid", 32'(v3),  32'd1);
      $display("cycle %0d: q2 id=%0d q3 grant=%b id=%0d", k, id2, g3, id3);
    end

`ifdef RR_ARB_LOCK_EN
    // Lock keeps id 0 for 6 cycles on the QUANTUM=2 instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    check_eq("lock start q2 id", 32'(id2), 32'd0);
    lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("lock hold q2 id",    32'(id2), 32'd0);
      check_eq("lock hold q2 grant", 32'(g2),  32'b0001);
      $display("lock hold: q2 grant=%b id=%0d", g2, id2);
    end
    lock = 1'b0;
    tick();
    check_eq("unlock q2 id", 32'(id2), 32'd1);
    $display("unlock: q2 grant=%b id=%0d", g2, id2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
